// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the processor I/O port peripherals (IN/OUT paths).
//   IO_WIDTH       : width of one port byte
//   OUT_FIFO_DEPTH : default number of queued bytes on the OUT path
//   io_byte_t      : one port byte
// -----------------------------------------------------------------------------
package io_pkg;

    localparam int IO_WIDTH       = 8;
    localparam int OUT_FIFO_DEPTH = 4;

    typedef logic [IO_WIDTH-1:0] io_byte_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage and a combinational head read.
// The caller is responsible for gating: push only when not full (or when a
// pop happens in the same cycle), pop only when not empty.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset (pointers and level to 0)
//   push   in   write wdata at the write pointer this cycle
//   pop    in   advance the read pointer this cycle
//   wdata  in   WIDTH  data to write
//   rdata  out  WIDTH  head entry (mem[rd_ptr])
//   level  out  occupancy 0..DEPTH
//   full   out  level == DEPTH
//   empty  out  level == 0
// -----------------------------------------------------------------------------
module sync_fifo
    import io_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = OUT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage carries no reset; stale contents are never visible because the
    // head is only meaningful while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two. The level counter
    // is kept separately so full and empty never need pointer comparison.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/out_port_buffer.sv
// -----------------------------------------------------------------------------
// out_port_buffer
// Output-side peripheral for the OUT instruction. Bytes retired at write-back
// are queued in a small FIFO and drained to an external device over a
// valid/ready handshake. A mirror of the last accepted byte is kept for debug
// and LED-style observation.
//
// Optional feature macro: OUT_PORT_OVF_EN
//   defined   -> 'overflow' output exists; sticky flag set on any dropped write
//   undefined -> no overflow port or register; dropped writes are silent
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   out_we     in   one-cycle strobe when an OUT instruction retires
//   out_data   in   WIDTH  byte written by the OUT instruction
//   out_full   out  FIFO full; used by the processor to stall the next OUT
//   dev_valid  out  head entry available to the device
//   dev_data   out  WIDTH  head entry (0 while empty)
//   dev_ready  in   device accepts the head entry this cycle
//   last_out   out  WIDTH  most recently accepted out_data
//   level      out  current occupancy 0..DEPTH
//   overflow   out  sticky drop flag (only with OUT_PORT_OVF_EN)
// -----------------------------------------------------------------------------
module out_port_buffer
    import io_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = OUT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     out_we,
    input  logic [WIDTH-1:0]         out_data,
    output logic                     out_full,
    output logic                     dev_valid,
    output logic [WIDTH-1:0]         dev_data,
    input  logic                     dev_ready,
    output logic [WIDTH-1:0]         last_out,
    output logic [$clog2(DEPTH):0]   level
`ifdef OUT_PORT_OVF_EN
    ,
    output logic                     overflow
`endif
);

    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             push;
    logic             pop;

    // A pop frees a slot in the same cycle, so a write while full is still
    // accepted when the device is draining the head.
    assign pop  = !fifo_empty && dev_ready;
    assign push = out_we && (!fifo_full || pop);

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (out_data),
        .rdata (fifo_rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_full  = fifo_full;
    assign dev_valid = !fifo_empty;

    // Storage is not reset, so the head is masked while empty to keep the
    // device bus at 0 after reset and between bursts.
    assign dev_data  = fifo_empty ? '0 : fifo_rdata;

    // Mirror follows only accepted writes; dropped bytes leave it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_out <= '0;
        end else if (push) begin
            last_out <= out_data;
        end
    end

`ifdef OUT_PORT_OVF_EN
    logic dropped;

    assign dropped = out_we && !push;

    // Sticky until reset so software can detect any loss since power-up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (dropped) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_out_port_buffer.sv
// -----------------------------------------------------------------------------
// tb_out_port_buffer
// Self-checking bench for out_port_buffer. A queue-based reference model holds
// the expected FIFO contents, mirror byte and overflow flag; outputs are
// compared on the falling clock edge. Directed scenarios are followed by a
// randomized phase. Builds with or without OUT_PORT_OVF_EN.
// -----------------------------------------------------------------------------
module tb_out_port_buffer;
    import io_pkg::*;

    localparam int DEPTH = OUT_FIFO_DEPTH;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic           clk;
    logic           rst;
    logic           out_we;
    io_byte_t       out_data;
    logic           out_full;
    logic           dev_valid;
    io_byte_t       dev_data;
    logic           dev_ready;
    io_byte_t       last_out;
    logic [LW-1:0]  level;
`ifdef OUT_PORT_OVF_EN
    logic           overflow;
`endif

    int checks = 0;
    int errors = 0;

    io_byte_t model_q[$];
    io_byte_t model_last;
    logic     model_ovf;

    out_port_buffer #(
        .WIDTH (IO_WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .out_we    (out_we),
        .out_data  (out_data),
        .out_full  (out_full),
        .dev_valid (dev_valid),
        .dev_data  (dev_data),
        .dev_ready (dev_ready),
        .last_out  (last_out),
        .level     (level)
`ifdef OUT_PORT_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_last = '0;
        model_ovf  = 1'b0;
    endtask

    // Occupancy-level rules: a write is taken if there is room or the head
    // leaves this cycle; otherwise it is lost and flagged.
    task automatic model_update(input logic we, input io_byte_t data, input logic ready);
        bit do_pop;
        bit do_push;
        do_pop  = (model_q.size() > 0) && ready;
        do_push = we && ((model_q.size() < DEPTH) || do_pop);
        if (we && !do_push) model_ovf = 1'b1;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
            model_q.push_back(data);
            model_last = data;
        end
    endtask

    task automatic check_output();
        io_byte_t exp_data;
        exp_data = (model_q.size() > 0) ? model_q[0] : '0;
        check_val("dev_valid", 32'(dev_valid), 32'(model_q.size() != 0));
        check_val("dev_data",  32'(dev_data),  32'(exp_data));
        check_val("level",     32'(level),     32'(model_q.size()));
        check_val("out_full",  32'(out_full),  32'(model_q.size() == DEPTH));
        check_val("last_out",  32'(last_out),  32'(model_last));
`ifdef OUT_PORT_OVF_EN
        check_val("overflow",  32'(overflow),  32'(model_ovf));
`endif
    endtask

    // Check the registered outputs mid-cycle, drive the next inputs, then
    // advance the model at the rising edge that consumes them.
    task automatic apply_stimulus(input logic we, input io_byte_t data, input logic ready);
        @(negedge clk);
        check_output();
        out_we    = we;
        out_data  = data;
        dev_ready = ready;
        @(posedge clk);
        model_update(we, data, ready);
    endtask

    initial begin
        rst       = 1'b0;
        out_we    = 1'b0;
        out_data  = '0;
        dev_ready = 1'b0;
        model_reset();

        // Reset state before any clock edge
        #1;
        check_output();
        @(negedge clk);
        rst = 1'b1;

        // Single byte passes straight through
        $display("[TB] single byte");
        apply_stimulus(1'b1, 8'h55, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        #1;
        check_val("single_last", 32'(last_out), 32'h55);
        check_val("single_level", 32'(level), 32'd0);

        // Back-pressure fill
        $display("[TB] back-pressure");
        apply_stimulus(1'b1, 8'hAA, 1'b0);
        apply_stimulus(1'b1, 8'h11, 1'b0);
        apply_stimulus(1'b1, 8'h22, 1'b0);
        apply_stimulus(1'b1, 8'h33, 1'b0);
        #1;
        check_val("bp_level", 32'(level), 32'd4);
        check_val("bp_full", 32'(out_full), 32'd1);
        check_val("bp_head", 32'(dev_data), 32'hAA);

        // Write while full with no pop is dropped
        $display("[TB] overflow");
        apply_stimulus(1'b1, 8'h99, 1'b0);
        #1;
        check_val("ovf_level", 32'(level), 32'd4);
        check_val("ovf_last", 32'(last_out), 32'h33);
        check_val("ovf_head", 32'(dev_data), 32'hAA);
`ifdef OUT_PORT_OVF_EN
        check_val("ovf_flag", 32'(overflow), 32'd1);
`endif

        // Push and pop together while full
        $display("[TB] push+pop when full");
        apply_stimulus(1'b1, 8'h44, 1'b1);
        #1;
        check_val("pp_level", 32'(level), 32'd4);
        check_val("pp_last", 32'(last_out), 32'h44);
        check_val("pp_head", 32'(dev_data), 32'h11);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-stream with three entries queued
        $display("[TB] mid-stream reset");
        apply_stimulus(1'b1, 8'hC1, 1'b0);
        apply_stimulus(1'b1, 8'hC2, 1'b0);
        apply_stimulus(1'b1, 8'hC3, 1'b0);
        #1;
        check_val("pre_rst_level", 32'(level), 32'd3);
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check_output();
        out_we    = 1'b0;
        dev_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Stream of ten bytes with the device always ready
        $display("[TB] wrap-around stream");
        for (int i = 1; i <= 10; i++) apply_stimulus(1'b1, io_byte_t'(i), 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        #1;
        check_val("wrap_last", 32'(last_out), 32'h0A);

        // Randomized traffic, device readiness rising phase by phase
        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 3) != 0),
                           io_byte_t'($urandom),
                           1'($urandom_range(0, 3) < (i / 100) + 1));
        end
        for (int i = 0; i < DEPTH + 1; i++) apply_stimulus(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check_output();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
